// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 initiator: valid/ready command in, one response out per command.
// Latency: psel 1 cycle after accept, penable at 2, rsp_valid at 3 with no wait states; +1 per wait state.
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready.
module apb_master_bridge #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                tim_psel,
    output logic                tim_penable,
    output logic                tim_pwrite,
    output logic [ADDR_W-1:0]   tim_paddr,
    output logic [DATA_W-1:0]   tim_pwdata,
    output logic [DATA_W/8-1:0] tim_pstrb,
    input  logic                tim_pready,
    input  logic [DATA_W-1:0]   tim_prdata,
    input  logic                tim_pslverr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    // Bus strobes decode straight from state so reset drops them without a clock edge.
    assign cmd_ready   = (state == ST_IDLE);
    assign tim_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
    assign tim_penable = (state == ST_ACCESS);
    assign rsp_valid   = (state == ST_RESP);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            tim_pwrite  <= 1'b0;
            tim_paddr   <= '0;
            tim_pwdata  <= '0;
            tim_pstrb   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_addr[1:0] != 2'b00) begin
                            // Misaligned: answer with an error and leave the bus untouched.
                            state       <= ST_RESP;
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                        end else begin
                            state      <= ST_SETUP;
                            wait_cnt   <= '0;
                            tim_pwrite <= cmd_write;
                            tim_paddr  <= cmd_addr;
                            tim_pwdata <= cmd_wdata;
                            tim_pstrb  <= cmd_write ? cmd_strb : '0;
                        end
                    end
                end
                ST_SETUP: state <= ST_ACCESS;
                ST_ACCESS: begin
                    if (tim_pready) begin
                        state       <= ST_RESP;
                        rsp_rdata   <= (tim_pwrite || tim_pslverr) ? '0 : tim_prdata;
                        rsp_err     <= tim_pslverr;
                        rsp_timeout <= 1'b0;
                    end else if ((TIMEOUT > 0) && (wait_cnt == CNT_LAST)) begin
                        state       <= ST_RESP;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
